// File: rtl/display_buf_pkg.sv
// Shared constants and helpers for the display scroll buffer.
package display_buf_pkg;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam logic [NIBBLE_W-1:0] PAD_NIBBLE = 4'h0;

  // Wrapping increment of a message index: the last valid index wraps to 0.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned len);
    return (idx == len - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Divide counter producing a one-cycle scroll tick every SCROLL_DIV clocks.
// hold freezes the count and masks the tick; clr restarts the count.
module scroll_tick_gen #(
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SCROLL_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCROLL_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = !hold && (r_cnt == LAST);

  // Counter runs 0..SCROLL_DIV-1 and wraps; held while hold is high.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (!hold) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scroll_buffer.sv
// Nibble message buffer feeding a four-digit LED driver with a scrolling window.
// Optional feature macro: SCROLL_PAUSE_EN adds a pause input that freezes scrolling.
module display_scroll_buffer
  import display_buf_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic                     clear,
`ifdef SCROLL_PAUSE_EN
  input  logic                     pause,
`endif
  output logic [15:0]              signal_to_display,
  output logic [$clog2(DEPTH):0]   msg_len,
  output logic                     overflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  logic [NIBBLE_W-1:0] r_buf [DEPTH];
  logic [LEN_W-1:0]    r_len;
  logic [IDX_W-1:0]    r_start;
  logic                r_ovf;
  logic [15:0]         r_disp;

  logic                w_ready;
  logic                w_wr;
  logic                w_tick;
  logic                w_hold;
  logic [IDX_W-1:0]    w_wr_idx0;
  logic [IDX_W-1:0]    w_wr_idx1;
  logic [LEN_W-1:0]    w_sum;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [15:0]         w_win;

`ifdef SCROLL_PAUSE_EN
  assign w_hold = pause;
`else
  assign w_hold = 1'b0;
`endif

  assign w_ready   = (r_len <= LEN_W'(DEPTH - 2));
  assign w_wr      = rx_valid && w_ready && !clear;
  assign w_wr_idx0 = r_len[IDX_W-1:0];
  assign w_wr_idx1 = r_len[IDX_W-1:0] + 1'b1;

  scroll_tick_gen #(
    .SCROLL_DIV (SCROLL_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .hold  (w_hold),
    .tick  (w_tick)
  );

  // Nibble RAM: high nibble of the byte lands first, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[w_wr_idx0] <= rx_data[7:4];
      r_buf[w_wr_idx1] <= rx_data[3:0];
    end
  end

  // Length, start pointer and sticky overflow; clear outranks write and tick.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_len   <= '0;
      r_start <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_len <= r_len + LEN_W'(2);
      end
      if (rx_valid && !w_ready) begin
        r_ovf <= 1'b1;
      end
      // Wrap test uses the length before any same-cycle write.
      if (w_tick) begin
        if (r_len > LEN_W'(DIGITS)) begin
          r_start <= IDX_W'(next_idx(32'(r_start), 32'(r_len)));
        end else begin
          r_start <= '0;
        end
      end
    end
  end

  // Window mux: digit k reads buf[(start+k) mod len], padding past the end.
  always_comb begin
    w_win    = '0;
    w_sum    = '0;
    w_rd_idx = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_sum = LEN_W'(r_start) + LEN_W'(k);
      if (w_sum >= r_len) begin
        w_sum = w_sum - r_len;
      end
      w_rd_idx = w_sum[IDX_W-1:0];
      if (LEN_W'(k) < r_len) begin
        w_win[NIBBLE_W*(DIGITS-1-k) +: NIBBLE_W] = r_buf[w_rd_idx];
      end else begin
        w_win[NIBBLE_W*(DIGITS-1-k) +: NIBBLE_W] = PAD_NIBBLE;
      end
    end
  end

  // Output register for the LED driver.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_disp <= '0;
    end else begin
      r_disp <= w_win;
    end
  end

  assign rx_ready          = w_ready;
  assign signal_to_display = r_disp;
  assign msg_len           = r_len;
  assign overflow          = r_ovf;

endmodule

// File: tb/tb_display_scroll_buffer.sv
// Directed self-checking bench for display_scroll_buffer (DEPTH=16, SCROLL_DIV=4).
// Optional feature macro: SCROLL_PAUSE_EN enables the pause section.
module tb_display_scroll_buffer;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        clear;
  logic        pause;
  logic [15:0] disp;
  logic [4:0]  msg_len;
  logic        overflow;

  int total;
  int bad;

  display_scroll_buffer #(
    .DEPTH      (16),
    .SCROLL_DIV (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .clear             (clear),
`ifdef SCROLL_PAUSE_EN
    .pause             (pause),
`endif
    .signal_to_display (disp),
    .msg_len           (msg_len),
    .overflow          (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Safety net against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected window for a message packed MSB-first, 16 nibbles max.
  function automatic logic [15:0] win(input logic [63:0] msg, input int len, input int s);
    logic [15:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      idx = (s + k) % len;
      r[15-4*k -: 4] = msg[63-4*idx -: 4];
    end
    return r;
  endfunction

  // Wait (bounded) until the display shows v.
  task automatic wait_val(input string tag, input logic [15:0] v, input int bound);
    int cnt;
    cnt = 0;
    while (disp !== v && cnt < bound) begin
      step();
      cnt++;
    end
    chk(tag, 32'(disp), 32'(v));
  endtask

  // Wait (bounded) for the next display change and check its value and spacing.
  task automatic next_change(input string tag, input logic [15:0] exp, input bit chk_int);
    logic [15:0] prev;
    int cnt;
    prev = disp;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (disp === prev && cnt < 8);
    chk(tag, 32'(disp), 32'(exp));
    if (chk_int) chk({tag, "_interval"}, 32'(cnt), 32'd4);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  logic [63:0] msg16;
  logic [15:0] exp8 [8];

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    clear    = 1'b0;
    pause    = 1'b0;
    msg16    = 64'hA194CC1023456789;
    exp8[0]  = 16'h194C; exp8[1] = 16'h94CC; exp8[2] = 16'h4CC1; exp8[3] = 16'hCC10;
    exp8[4]  = 16'hC10A; exp8[5] = 16'h10A1; exp8[6] = 16'h0A19; exp8[7] = 16'hA194;

    // Reset state
    #400;
    #1;
    chk("rst_disp", 32'(disp), 32'h0000);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_len", 32'(msg_len), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Two bytes, static 4-digit display
    send(8'hA1);
    chk("len_after_a1", 32'(msg_len), 32'd2);
    send(8'h94);
    chk("len_after_94", 32'(msg_len), 32'd4);
    step();
    chk("disp_a194", 32'(disp), 32'hA194);
    for (int i = 0; i < 80; i++) begin
      step();
      chk("static_a194", 32'(disp), 32'hA194);
    end

    // Length 8: scrolling with wrap
    send(8'hCC);
    send(8'h10);
    chk("len8", 32'(msg_len), 32'd8);
    wait_val("scroll8_first", 16'h194C, 12);
    for (int i = 1; i < 8; i++) next_change("scroll8", exp8[i], 1'b1);

    // Fill to capacity, then a dropped byte
    send(8'h23);
    send(8'h45);
    send(8'h67);
    chk("ready_14", 32'(rx_ready), 32'd1);
    send(8'h89);
    chk("full_len", 32'(msg_len), 32'd16);
    chk("full_ready", 32'(rx_ready), 32'd0);
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    send(8'hFF);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_len", 32'(msg_len), 32'd16);
    wait_val("scroll16_sync", 16'hA194, 80);
    for (int s = 1; s <= 16; s++) next_change("scroll16", win(msg16, 16, s % 16), 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Clear colliding with a write offer and a tick (tick lands 3 edges after a change)
    step();
    step();
    clear    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    step();
    clear    = 1'b0;
    rx_valid = 1'b0;
    chk("clr_len", 32'(msg_len), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_ready", 32'(rx_ready), 32'd1);
    chk("clr_disp", 32'(disp), 32'h0000);
    step();
    chk("clr_disp_next", 32'(disp), 32'h0000);

    // Short message after clear
    send(8'h7E);
    chk("len_7e", 32'(msg_len), 32'd2);
    step();
    chk("disp_7e00", 32'(disp), 32'h7E00);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("static_7e00", 32'(disp), 32'h7E00);
    end

`ifdef SCROLL_PAUSE_EN
    // Pause freezes the window; release resumes from the same start
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("pause_len8", 32'(msg_len), 32'd8);
    wait_val("pause_sync", 16'h7E11, 40);
    pause = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("paused", 32'(disp), 32'h7E11);
    end
    pause = 1'b0;
    next_change("resume", 16'hE112, 1'b0);
    next_change("resume2", 16'h1122, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
